// File: rtl/aes_mode_engine.sv
// ECB/CBC/CTR chaining front end for a raw AES block core.
// Blocks are tracked in an in-order ring: wr on issue, done on core return, rd on output.
module aes_mode_engine #(
   parameter int DATA_W = 128,
   parameter int CTR_W  = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_inv,
   input  logic [DATA_W-1:0] cfg_iv,
   output logic              cfg_err,
   output logic              busy,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              core_in_valid,
   input  logic              core_in_ready,
   output logic [DATA_W-1:0] core_in_data,
   output logic              core_inv,
   input  logic              core_out_valid,
   input  logic [DATA_W-1:0] core_out_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      MODE_ECB = 2'd0,
      MODE_CBC = 2'd1,
      MODE_CTR = 2'd2,
      MODE_RSV = 2'd3
   } mode_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } ent_t;

   mode_e             mode_q, mode_d;
   logic              inv_q, inv_d;
   logic [DATA_W-1:0] chain_q, chain_d;
   logic [PW-1:0]     wr_q, wr_d, done_q, done_d, rd_q, rd_d;
   logic              cfg_err_q;
   ent_t              buf_q [DEPTH];

   logic [PW-1:0]     occ, outst;
   logic              busy_raw, cbc_enc, issue_ok, issue, ret, pop, cfg_load;
   logic [DATA_W-1:0] ins_data;

   assign occ      = wr_q - rd_q;
   assign outst    = wr_q - done_q;
   assign busy_raw = (occ != '0);
   assign cbc_enc  = (mode_q == MODE_CBC) && !inv_q;
   // CBC encrypt needs the previous ciphertext, so only one block may be in the core
   assign issue_ok = !rst && (occ < PW'(DEPTH)) && !cfg_valid && core_in_ready &&
                     !(cbc_enc && (outst != '0));
   assign issue    = s_valid && issue_ok;
   assign ret      = core_out_valid && (outst != '0);
   assign pop      = m_valid && m_ready;
   assign cfg_load = cfg_valid && !busy_raw;

   assign s_ready       = issue_ok;
   assign core_in_valid = issue;
   assign core_inv      = inv_q && (mode_q != MODE_CTR);
   assign busy          = !rst && busy_raw;
   assign m_valid       = !rst && (rd_q != done_q);
   assign m_data        = buf_q[rd_q[AW-1:0]].data;
   assign m_last        = buf_q[rd_q[AW-1:0]].last;
   assign cfg_err       = cfg_err_q;

   always_comb begin
      mode_d       = mode_q;
      inv_d        = inv_q;
      chain_d      = chain_q;
      core_in_data = s_data;
      ins_data     = '0;
      case (mode_q)
         MODE_CBC: begin
            if (!inv_q) begin
               core_in_data = s_data ^ chain_q;
            end else begin
               ins_data = chain_q;
               if (issue) chain_d = s_data;
            end
         end
         MODE_CTR: begin
            core_in_data = chain_q;
            ins_data     = s_data;
            // counter field wraps without carrying into the upper bits
            if (issue) chain_d[CTR_W-1:0] = chain_q[CTR_W-1:0] + CTR_W'(1);
         end
         default: ;
      endcase
      if (ret && cbc_enc) chain_d = core_out_data;
      if (cfg_load) begin
         mode_d  = (cfg_mode == MODE_RSV) ? MODE_ECB : mode_e'(cfg_mode);
         inv_d   = cfg_inv;
         chain_d = cfg_iv;
      end
      wr_d   = wr_q + PW'(issue);
      done_d = done_q + PW'(ret);
      rd_d   = rd_q + PW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= MODE_ECB;
         inv_q     <= 1'b0;
         chain_q   <= '0;
         wr_q      <= '0;
         done_q    <= '0;
         rd_q      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         inv_q     <= inv_d;
         chain_q   <= chain_d;
         wr_q      <= wr_d;
         done_q    <= done_d;
         rd_q      <= rd_d;
         cfg_err_q <= cfg_valid && busy_raw;
      end
   end

   // issue and return never target the same slot: outstanding < DEPTH whenever issue fires
   always_ff @(posedge clk) begin
      if (issue) buf_q[wr_q[AW-1:0]] <= '{data: ins_data, last: s_last};
      if (ret)   buf_q[done_q[AW-1:0]].data <= core_out_data ^ buf_q[done_q[AW-1:0]].data;
   end
endmodule

// File: tb/tb_aes_mode_engine.sv
// Scoreboard bench for aes_mode_engine with a 3-cycle inverting core stub.
module tb_aes_mode_engine;
   localparam int DW = 128;
   localparam int CW = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_valid = 1'b0, cfg_inv = 1'b0, cfg_err, busy;
   logic [1:0] cfg_mode = '0;
   logic [DW-1:0] cfg_iv = '0, s_data = '0, m_data, core_in_data, core_out_data;
   logic s_valid = 1'b0, s_ready, s_last = 1'b0, m_valid, m_ready = 1'b1, m_last;
   logic core_in_valid, core_in_ready = 1'b1, core_inv, core_out_valid;

   always #5 clk = ~clk;

   aes_mode_engine #(.DATA_W(DW), .CTR_W(CW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_inv(cfg_inv), .cfg_iv(cfg_iv),
      .cfg_err(cfg_err), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
      .core_in_data(core_in_data), .core_inv(core_inv),
      .core_out_valid(core_out_valid), .core_out_data(core_out_data)
   );

   // core stub: never reset, so in-flight results survive a DUT reset
   logic [2:0] sv = '0;
   logic [DW-1:0] sd [3];
   always @(posedge clk) begin
      sv    <= {sv[1:0], core_in_valid & core_in_ready};
      sd[0] <= ~core_in_data;
      sd[1] <= sd[0];
      sd[2] <= sd[1];
   end
   assign core_out_valid = sv[2];
   assign core_out_data  = sd[2];

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t exp_q[$];
   logic [DW-1:0] ciq[$];
   int checks = 0, errors = 0, cyc = 0, first_mv = -1;
   int acc_cyc = 0, stalls = 0, sent = 0, t0 = 0, tot_st = 0;
   bit rnd_en = 1'b0, sdone = 1'b0;
   logic [1:0] m_mode = '0;
   logic m_inv = 1'b0;
   logic [DW-1:0] m_chain = '0;

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endfunction

   // reference: mode equations applied to the message stream
   function void push_exp(input logic [DW-1:0] d, input logic l);
      logic [DW-1:0] e;
      case (m_mode)
         2'd1: begin
            if (!m_inv) begin
               e = ~(d ^ m_chain);
               m_chain = e;
            end else begin
               e = ~d ^ m_chain;
               m_chain = d;
            end
         end
         2'd2: begin
            e = d ^ ~m_chain;
            m_chain[CW-1:0] = m_chain[CW-1:0] + 1;
         end
         default: e = ~d;
      endcase
      exp_q.push_back('{d: e, l: l});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_en) begin
         m_ready       = ($urandom_range(0, 2) != 0);
         core_in_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      stalls  = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            push_exp(d, l);
            sent++;
         end else begin
            stalls++;
         end
         step();
      end
      s_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic cfg_load(input logic [1:0] mode, input logic inv, input logic [DW-1:0] iv,
                           input logic exp_err);
      cfg_valid = 1'b1;
      cfg_mode  = mode;
      cfg_inv   = inv;
      cfg_iv    = iv;
      step();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("cfg_err", cfg_err, exp_err);
      if (!exp_err) begin
         m_mode  = mode;
         m_inv   = inv;
         m_chain = iv;
         chk("core_inv", core_inv, inv && (mode != 2'd2));
      end
      step();
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) ok = 1'b1;
         step();
      end
      if (!ok) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      logic [DW-1:0] v, iv, c0, c1;
      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         forever begin
            exp_t e;
            @(negedge clk);
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (core_in_valid && core_in_ready) ciq.push_back(core_in_data);
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("m_data", m_data, e.d);
                  chk("m_last", m_last, e.l);
               end
            end
         end
         begin
            #500000;
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1);
         end
      join_none

      // reset state
      s_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_core_in_valid", core_in_valid, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_busy", busy, 0);
      s_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_core_inv", core_inv, 0);
      chk("post_rst_s_ready", s_ready, 1);
      step();

      // ECB back-to-back
      cfg_load(2'd0, 1'b0, '0, 1'b0);
      first_mv = -1;
      tot_st = 0;
      for (int i = 0; i < 4; i++) begin
         send(DW'(i), i == 3);
         if (i == 0) t0 = acc_cyc;
         tot_st += stalls;
      end
      chk("t1_no_stall", tot_st, 0);
      drain();
      chk("t1_latency", first_mv - t0, 4);

      // CBC encrypt
      cfg_load(2'd1, 1'b0, 128'h5, 1'b0);
      ciq.delete();
      send(128'hA, 1'b0);
      send(128'hB, 1'b1);
      chk("t2_stall", stalls, 3);
      drain();
      v = 128'hF;
      chk("t2_ci_n", ciq.size(), 2);
      chk("t2_ci0", ciq[0], v);
      chk("t2_ci1", ciq[1], 128'hB ^ ~v);

      // CBC decrypt
      cfg_load(2'd1, 1'b1, 128'h5, 1'b0);
      c0 = rnd128();
      c1 = rnd128();
      send(c0, 1'b0);
      send(c1, 1'b1);
      chk("t3_no_stall", stalls, 0);
      drain();

      // CTR wrap without carry
      iv = {64'h0, 32'h1, 32'hFFFF_FFFF};
      cfg_load(2'd2, 1'b0, iv, 1'b0);
      ciq.delete();
      send(rnd128(), 1'b0);
      send(rnd128(), 1'b1);
      drain();
      chk("t4_ctr0", ciq[0], iv);
      chk("t4_ctr1", ciq[1], {64'h0, 32'h1, 32'h0});

      // backpressure, full buffer, rejected config
      cfg_load(2'd0, 1'b0, '0, 1'b0);
      m_ready = 1'b0;
      sent = 0;
      sdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(rnd128(), i == 5);
            sdone = 1'b1;
         end
      join_none
      repeat (10) step();
      @(negedge clk);
      chk("t5_sent", sent, 4);
      chk("t5_s_ready", s_ready, 0);
      chk("t5_busy", busy, 1);
      step();
      cfg_load(2'd1, 1'b1, '1, 1'b1);
      @(negedge clk);
      chk("t5_mode_kept", core_inv, 0);
      chk("t5_sent2", sent, 4);
      step();
      m_ready = 1'b1;
      for (int i = 0; i < 200 && !sdone; i++) step();
      chk("t5_sender_done", sdone, 1);
      drain();

      // reset with blocks outstanding
      cfg_load(2'd0, 1'b0, '0, 1'b0);
      send(rnd128(), 1'b0);
      send(rnd128(), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_s_ready_rst", s_ready, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_busy", busy, 0);
      chk("t6_m_valid", m_valid, 0);
      exp_q.delete();
      step();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t6_no_out", m_valid, 0);
         step();
      end

      // randomized messages across all modes
      rnd_en = 1'b1;
      for (int r = 0; r < 10; r++) begin
         int n;
         logic [1:0] md;
         md = 2'($urandom_range(0, 3));
         cfg_load(md, 1'($urandom_range(0, 1)), rnd128(), 1'b0);
         n = $urandom_range(3, 12);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(rnd128(), i == n - 1);
         end
         drain();
      end
      rnd_en = 1'b0;
      m_ready = 1'b1;
      core_in_ready = 1'b1;
      step();
      chk("end_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_mode_engine.md
Name: aes_mode_engine

Overview:
Block-chaining front end placed between the bus-side plaintext/ciphertext stream and the AES core. It applies ECB, CBC or CTR mode around the core's raw block transform. It tracks up to DEPTH blocks in flight in an in-order circular buffer and exposes valid/ready streams on both sides. CBC-encrypt issues one block at a time. ECB, CBC-decrypt and CTR keep the core pipeline full.

Parameters:
DATA_W, 128, block width in bits.
CTR_W, 32, width of the CTR counter field (low bits of the counter block), 1..DATA_W.
DEPTH, 4, in-flight/result buffer entries; power of 2, >=2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  load mode/inv/iv; honoured only when idle
cfg_mode  in  2  0=ECB 1=CBC 2=CTR 3=reserved (treated as ECB)
cfg_inv  in  1  0=encrypt 1=decrypt
cfg_iv  in  DATA_W  IV (CBC) or initial counter block (CTR)
cfg_err  out  1  1-cycle pulse: cfg_valid seen while busy (config ignored)
busy  out  1  buffer non-empty
s_valid  in  1  input block valid
s_ready  out  1  input block accepted when s_valid&s_ready
s_data  in  DATA_W  input block
s_last  in  1  last block of message, carried to m_last
m_valid  out  1  output block valid
m_ready  in  1  consumer ready
m_data  out  DATA_W  output block
m_last  out  1  copy of s_last for this block
core_in_valid  out  1  issue block to core
core_in_ready  in  1  core can accept
core_in_data  out  DATA_W  block to core
core_inv  out  1  cfg_inv & (mode!=CTR)
core_out_valid  in  1  core result valid (no backpressure, in order)
core_out_data  in  DATA_W  core result

Behaviour:
- State: mode, inv, chain register (DATA_W), buffer[DEPTH] of {data, last}, pointers wr/done/rd of log2(DEPTH)+1 bits.
- Pointer roles: wr advances on issue, done on core return, rd on output. occ = wr-rd; outstanding = wr-done.
- Reset: mode=ECB, inv=0, chain=0, pointers=0. Outputs: s_ready=0, m_valid=0, core_in_valid=0, cfg_err=0, busy=0.
- Reset asserted mid-operation discards all in-flight blocks. Late core_out_valid after reset is ignored while outstanding==0.
- Config: when cfg_valid & !busy, latch mode/inv and chain<=cfg_iv. cfg_valid & busy pulses cfg_err the next cycle and leaves state unchanged.
- issue_ok = occ<DEPTH & !cfg_valid & core_in_ready & !(mode==CBC & !inv & outstanding!=0).
- s_ready = issue_ok; core_in_valid = s_valid & issue_ok. Combinational; s_data must not depend on s_ready.
- Issue, per mode:
  - ECB: core_in=s_data; buffer[wr].data<=0.
  - CBC enc: core_in=s_data^chain; buffer<=0.
  - CBC dec: core_in=s_data; buffer<=chain; chain<=s_data.
  - CTR: core_in=chain; buffer<=s_data; chain[CTR_W-1:0]<=chain[CTR_W-1:0]+1. Wraps mod 2^CTR_W; upper bits are never carried into.
- In all modes buffer[wr].last<=s_last and wr++.
- Return (core_out_valid & outstanding!=0): buffer[done].data <= core_out_data ^ buffer[done].data; done++. CBC enc also sets chain<=core_out_data.
- Output: m_valid = (rd!=done); m_data/m_last = buffer[rd]. rd++ on m_valid&m_ready.
- Latency: a core return in cycle t gives m_valid in cycle t+1. Total latency = core latency + 1.
- Simultaneous events: issue, return and output in the same cycle are all legal and independent. occ after the cycle = occ + issue - output.
- Full: occ==DEPTH holds s_ready=0. Empty: m_valid=0, busy=0.
- m_last has no effect on state; chain persists until the next cfg load.

Test Plan:
Core stub for all tests: returns core_in_data ^ {DATA_W{1'b1}} after 3 cycles; core_in_ready=1 unless stated.
1. ECB, 4 blocks 0,1,2,3 back-to-back, m_ready=1 -> m_data ~0,~1,~2,~3. First m_valid 4 cycles after first issue. s_ready never drops.
2. CBC enc, iv=0x5, blocks 0xA,0xB -> core_in 0xF, then after the first return core_in = 0xB ^ ~0xF. s_ready low while 1 block is outstanding.
3. CBC dec, iv=0x5, blocks C0,C1 -> outputs ~C0^0x5 and ~C1^C0, issued on consecutive cycles.
4. CTR, CTR_W=32, iv low word 0xFFFFFFFF, upper bits 0x1 -> counters ...1_FFFFFFFF then ...1_00000000 (no carry). Output = data ^ ~counter.
5. m_ready=0 with 6 blocks offered -> s_ready falls after 4 issues. A cfg_valid during this pulses cfg_err=1 and mode is unchanged. Releasing m_ready drains outputs in order, with m_last on the block tagged s_last.
6. rst asserted with 2 blocks outstanding -> next cycle busy=0, m_valid=0. Late stub returns produce no output.
